// File: rtl/serial_word_arith_if.sv
// Bundle of serial operand/result signals for serial_word_arith.
// master drives operand bits and mode; slave (the arithmetic unit) returns results.
interface serial_word_arith_if #(
  parameter int WIDTH = 8
);
  logic             bitIn;
  logic             bitValid;
  logic             start;
  logic [1:0]       mode;
  logic             bitOut;
  logic             outValid;
  logic [WIDTH-1:0] wordOut;
  logic             wordValid;
  logic             overflow;

  modport master (
    output bitIn, bitValid, start, mode,
    input  bitOut, outValid, wordOut, wordValid, overflow
  );

  modport slave (
    input  bitIn, bitValid, start, mode,
    output bitOut, outValid, wordOut, wordValid, overflow
  );
endinterface

// File: rtl/serial_word_arith.sv
// Bit-serial LSB-first pass/negate/increment/decrement with a same-cycle result bit.
// Define SERIAL_WORD_PARALLEL_OUT_EN to build the parallel wordOut/wordValid/overflow path.
module serial_word_arith #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_word_arith_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_DEC  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic             flag_q, flag_d;

  logic             new_word;
  logic             bit_fire;
  logic             last_bit;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_mode;
  logic             cur_flag;
  logic             bit_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_PASS;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      flag_q  <= flag_d;
    end
  end

  // A start bit (even mid-word) restarts at index 0 with the freshly presented mode;
  // increment and decrement begin with their carry/borrow set.
  always_comb begin
    new_word = bus.bitValid & bus.start;
    bit_fire = (state_q == IDLE) ? new_word : bus.bitValid;
    cur_idx  = new_word ? '0 : idx_q;
    cur_mode = new_word ? bus.mode : mode_q;
    cur_flag = new_word ? bus.mode[1] : flag_q;
    last_bit = bit_fire && (cur_idx == IDX_W'(WIDTH - 1));
    bit_out  = 1'b0;
    case (cur_mode)
      MODE_PASS: bit_out = bus.bitIn;
      MODE_NEG:  bit_out = bus.bitIn ^ cur_flag;
      MODE_INC:  bit_out = bus.bitIn ^ cur_flag;
      MODE_DEC:  bit_out = bus.bitIn ^ cur_flag;
      default:   bit_out = 1'b0;
    endcase
    bus.outValid = bit_fire;
    bus.bitOut   = bit_fire & bit_out;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    flag_d  = flag_q;
    if (bit_fire) begin
      mode_d = cur_mode;
      case (cur_mode)
        MODE_PASS: flag_d = 1'b0;
        MODE_NEG:  flag_d = cur_flag | bus.bitIn;
        MODE_INC:  flag_d = cur_flag & bus.bitIn;
        MODE_DEC:  flag_d = cur_flag & ~bus.bitIn;
        default:   flag_d = 1'b0;
      endcase
      if (last_bit) begin
        state_d = IDLE;
        idx_d   = '0;
        flag_d  = 1'b0;
      end else begin
        state_d = RUN;
        idx_d   = cur_idx + IDX_W'(1);
      end
    end
  end

`ifdef SERIAL_WORD_PARALLEL_OUT_EN
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             ovf_q, ovf_d;
  logic             ovf_now;

  // Overflow is only meaningful on the top bit, where the sign flips unexpectedly.
  always_comb begin
    ovf_now = 1'b0;
    case (cur_mode)
      MODE_NEG: ovf_now = bus.bitIn & ~cur_flag;
      MODE_INC: ovf_now = cur_flag & ~bus.bitIn;
      MODE_DEC: ovf_now = cur_flag & bus.bitIn;
      default:  ovf_now = 1'b0;
    endcase
  end

  always_comb begin
    result_d     = result_q;
    word_d       = word_q;
    ovf_d        = ovf_q;
    word_valid_d = 1'b0;
    if (bit_fire) begin
      result_d[cur_idx] = bit_out;
    end
    if (last_bit) begin
      word_d       = result_d;
      ovf_d        = ovf_now;
      word_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      result_q     <= result_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.wordOut   = word_q;
  assign bus.wordValid = word_valid_q;
  assign bus.overflow  = ovf_q;
`else
  assign bus.wordOut   = '0;
  assign bus.wordValid = 1'b0;
  assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_arith.sv
// Self-checking bench for serial_word_arith: arithmetic word model plus literal spot checks.
// Parallel-output expectations follow SERIAL_WORD_PARALLEL_OUT_EN.
module tb_serial_word_arith;
  localparam int W = 8;
`ifdef SERIAL_WORD_PARALLEL_OUT_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_arith_if #(.WIDTH(W)) bus ();
  serial_word_arith #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  logic         e_ov, e_bo, e_bo_care, e_wv, e_ovf;
  logic [W-1:0] e_wo;

  bit           m_active = 1'b0;
  int           m_idx    = 0;
  logic [1:0]   m_mode   = 2'b00;
  logic [W-1:0] m_op     = '0;
  logic         h_wv     = 1'b0;
  logic [W-1:0] h_wo     = '0;
  logic         h_ovf    = 1'b0;

  logic         s_bo, s_ov, s_wv, s_ovf;
  logic [W-1:0] s_wo;

  function automatic logic [W-1:0] model_result(input logic [1:0] md, input logic [W-1:0] op);
    case (md)
      2'b00:   return op;
      2'b01:   return -op;
      2'b10:   return op + W'(1);
      default: return op - W'(1);
    endcase
  endfunction

  function automatic logic model_ovf(input logic [1:0] md, input logic [W-1:0] op);
    logic [W-1:0] most_neg = {1'b1, {(W-1){1'b0}}};
    case (md)
      2'b01:   return op == most_neg;
      2'b10:   return op == ~most_neg;
      2'b11:   return op == most_neg;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("outValid", 32'(bus.outValid), 32'(e_ov));
      if (e_bo_care) checkOutput("bitOut", 32'(bus.bitOut), 32'(e_bo));
      checkOutput("wordValid", 32'(bus.wordValid), 32'(e_wv));
      checkOutput("wordOut", 32'(bus.wordOut), 32'(e_wo));
      checkOutput("overflow", 32'(bus.overflow), 32'(e_ovf));
    end
  end

  // One clock cycle: drive inputs, predict outputs, sample at negedge, advance model at posedge.
  task automatic applyStimulus(input logic b, input logic v, input logic s,
                               input logic [1:0] md, input logic r);
    logic [W-1:0] op_now;
    logic [W-1:0] res;
    logic [1:0]   mode_now;
    int           idx_now;
    bit           fires;
    bus.bitIn = b;
    bus.bitValid = v;
    bus.start = s;
    bus.mode = md;
    rst = r;
    op_now = m_op;
    mode_now = m_mode;
    idx_now = m_idx;
    fires = 1'b0;
    if (v && s) begin
      fires = 1'b1;
      mode_now = md;
      idx_now = 0;
      op_now = '0;
    end else if (v && m_active) begin
      fires = 1'b1;
    end
    res = '0;
    if (fires) begin
      op_now[idx_now] = b;
      res = model_result(mode_now, op_now);
      e_ov = 1'b1;
      e_bo = res[idx_now];
      e_bo_care = 1'b1;
    end else begin
      e_ov = 1'b0;
      e_bo = 1'b0;
      e_bo_care = !m_active;
    end
    e_wv = h_wv;
    e_wo = h_wo;
    e_ovf = h_ovf;
    @(negedge clk);
    s_bo = bus.bitOut;
    s_ov = bus.outValid;
    s_wv = bus.wordValid;
    s_wo = bus.wordOut;
    s_ovf = bus.overflow;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_idx = 0;
      m_op = '0;
      m_mode = 2'b00;
      h_wv = 1'b0;
      h_wo = '0;
      h_ovf = 1'b0;
    end else begin
      h_wv = 1'b0;
      if (fires) begin
        m_mode = mode_now;
        m_op = op_now;
        if (idx_now == W - 1) begin
          m_active = 1'b0;
          m_idx = 0;
          if (ParEn) begin
            h_wv = 1'b1;
            h_wo = res;
            h_ovf = model_ovf(mode_now, op_now);
          end
        end else begin
          m_active = 1'b1;
          m_idx = idx_now + 1;
        end
      end
    end
    #1;
  endtask

  // Mode input is scrambled after bit 0 so the latched mode must be used.
  task automatic send_bits(input logic [1:0] md, input logic [W-1:0] val, input int nbits,
                           input int stall_after, input int stall_len, output logic [W-1:0] ser);
    ser = '0;
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(val[i], 1'b1, (i == 0), (i == 0) ? md : ~md, 1'b0);
      ser[i] = s_bo;
      if (i == stall_after) begin
        for (int k = 0; k < stall_len; k++) begin
          applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'(k % 2), ~md, 1'b0);
          checkOutput("stall outValid", 32'(s_ov), 32'd0);
        end
      end
    end
  endtask

  task automatic send_word(input string name, input logic [1:0] md, input logic [W-1:0] val,
                           input int stall_after, input int stall_len,
                           input logic [W-1:0] exp_word, input logic exp_ovf);
    logic [W-1:0] ser;
    send_bits(md, val, W, stall_after, stall_len, ser);
    checkOutput({name, " serial"}, 32'(ser), 32'(exp_word));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput({name, " wordValid"}, 32'(s_wv), 32'(ParEn));
    checkOutput({name, " wordOut"}, 32'(s_wo), ParEn ? 32'(exp_word) : 32'd0);
    checkOutput({name, " overflow"}, 32'(s_ovf), ParEn ? 32'(exp_ovf) : 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput({name, " wordValid drop"}, 32'(s_wv), 32'd0);
  endtask

  logic [W-1:0] junk;

  initial begin
    bus.bitIn = 1'b0;
    bus.bitValid = 1'b0;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    checkOutput("reset outValid", 32'(s_ov), 32'd0);
    checkOutput("reset bitOut", 32'(s_bo), 32'd0);
    checkOutput("reset wordOut", 32'(s_wo), 32'd0);

    send_word("neg 06", 2'b01, 8'h06, -1, 0, 8'hFA, 1'b0);
    send_word("neg 80", 2'b01, 8'h80, -1, 0, 8'h80, 1'b1);
    send_word("neg 00", 2'b01, 8'h00, -1, 0, 8'h00, 1'b0);
    send_word("inc 7F", 2'b10, 8'h7F, -1, 0, 8'h80, 1'b1);
    send_word("dec 00", 2'b11, 8'h00, -1, 0, 8'hFF, 1'b0);
    send_word("dec 80", 2'b11, 8'h80, -1, 0, 8'h7F, 1'b1);
    send_word("pass 3C", 2'b00, 8'h3C, -1, 0, 8'h3C, 1'b0);
    send_word("inc 05 stall", 2'b10, 8'h05, 3, 3, 8'h06, 1'b0);

    send_bits(2'b10, 8'h33, 4, -1, 0, junk);
    send_word("neg 01 restart", 2'b01, 8'h01, -1, 0, 8'hFF, 1'b0);

    send_bits(2'b11, 8'h5C, 7, -1, 0, junk);
    send_word("inc FE restart", 2'b10, 8'hFE, -1, 0, 8'hFF, 1'b0);

    send_bits(2'b00, 8'h5A, 5, -1, 0, junk);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("post-reset outValid", 32'(s_ov), 32'd0);
    checkOutput("post-reset bitOut", 32'(s_bo), 32'd0);
    checkOutput("post-reset wordValid", 32'(s_wv), 32'd0);
    checkOutput("post-reset wordOut", 32'(s_wo), 32'd0);
    checkOutput("post-reset overflow", 32'(s_ovf), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    checkOutput("idle bit without start", 32'(s_ov), 32'd0);
    send_word("pass A5", 2'b00, 8'hA5, -1, 0, 8'hA5, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
